// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_ctrl
//  Purpose  : Sequencer for the MIPS multiply/divide unit and owner of the
//             architectural HI/LO registers. Multiplies complete after a
//             fixed latency; divides use a 32-step restoring divider followed
//             by a sign-fixup cycle. Stalls HI/LO consumers and further
//             multdiv instructions while an operation is in flight.
//  Ports    : clk, resetn (async, active low)
//             start, op[2:0], srca[31:0], srcb[31:0]  - instruction from EX
//             read_req                                - MFHI/MFLO in EX
//             flush                                   - abort / ignore start
//             stall, busy, done                       - status
//             hi[31:0], lo[31:0]                      - architectural HI/LO
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int MULT_LAT  = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        read_req,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;

    localparam logic [4:0] c_mul_cnt_init = 5'(MULT_LAT - 1);
    localparam logic [4:0] c_div_cnt_init = 5'(DIV_ITERS - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    // r_a holds multiplicand, or dividend bits shifting out / quotient bits
    // shifting in; r_b holds multiplier or divisor magnitude.
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_orig_a;
    logic        r_signed;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div_zero;

    logic        w_accept;
    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quot_nxt;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = (r_state == S_IDLE) && start && !flush;

    // ---------------- divide operand preparation ----------------
    assign w_div_signed = (op == c_op_div);
    assign w_abs_a = (w_div_signed && srca[31]) ? (~srca + 32'd1) : srca;
    assign w_abs_b = (w_div_signed && srcb[31]) ? (~srcb + 32'd1) : srcb;

    // ---------------- multiplier ----------------
    // Sign-extending both operands to 64 bits makes the truncated 64-bit
    // product correct for both signed and unsigned forms.
    assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
    assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // ---------------- restoring divide step ----------------
    // Remainder stays below the divisor, so the difference always fits in
    // 32 bits when the trial subtraction succeeds.
    assign w_shift    = {r_rem, r_a[31]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_rem_nxt  = w_ge ? (w_shift[31:0] - r_b) : w_shift[31:0];
    assign w_quot_nxt = {r_a[30:0], w_ge};

    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? (~r_a + 32'd1) : r_a;
    assign w_rem_fix  = r_sign_a ? (~r_rem + 32'd1) : r_rem;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op == c_op_mult || op == c_op_multu) begin
                        w_state_nxt = S_MUL;
                    end else if (op == c_op_div || op == c_op_divu) begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 5'd0) begin
                    w_state_nxt = S_IDLE;
                    done        = 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 5'd0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                done        = !flush;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        busy  = (r_state != S_IDLE);
        stall = busy && (start || read_req);
    end

    // ---------------- datapath and HI/LO ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= 5'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_rem      <= 32'd0;
            r_orig_a   <= 32'd0;
            r_signed   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            c_op_mthi: r_hi <= srca;
                            c_op_mtlo: r_lo <= srca;
                            c_op_mult, c_op_multu: begin
                                r_a      <= srca;
                                r_b      <= srcb;
                                r_signed <= (op == c_op_mult);
                                r_cnt    <= c_mul_cnt_init;
                            end
                            c_op_div, c_op_divu: begin
                                r_a        <= w_abs_a;
                                r_b        <= w_abs_b;
                                r_rem      <= 32'd0;
                                r_orig_a   <= srca;
                                r_sign_a   <= w_div_signed & srca[31];
                                r_sign_b   <= w_div_signed & srcb[31];
                                r_div_zero <= (srcb == 32'd0);
                                r_cnt      <= c_div_cnt_init;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        r_rem <= w_rem_nxt;
                        r_a   <= w_quot_nxt;
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        // Divide by zero bypasses the sign fixup entirely.
                        if (r_div_zero) begin
                            r_hi <= r_orig_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_ctrl
//  Purpose  : Self-checking bench for multdiv_ctrl with an arithmetic
//             reference model of HI/LO and of operation latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int MULT_LAT = 2;
    localparam int DIV_LAT  = 33;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        read_req;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    multdiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_ITERS(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .srca(srca),
        .srcb(srcb), .read_req(read_req), .flush(flush), .stall(stall),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: architectural effect of one accepted instruction.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      q;
        longint      r;
        logic [63:0] p;
        case (o)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
        if (o <= 3'd1) return MULT_LAT;
        if (o <= 3'd3) return DIV_LAT;
        return 0;
    endfunction

    // Issue one instruction and observe busy length and done pulses.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output int ndone);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        nbusy = 0; ndone = 0;
        while (busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 1000));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; op = 3'd0; srca = 32'd0; srcb = 32'd0;
        read_req = 1'b1; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, stall} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got busy/done/stall=%b required 000", {busy, done, stall});
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_hilo: got %h/%h required 0/0", hi, lo);
        end
        read_req = 1'b0;
        resetn = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        logic [2:0]  o;
        logic [31:0] a, b;
        int nb, nd;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:       begin o = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                1:       begin o = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                2:       begin o = 3'd0; a = 32'h8000_0000; b = 32'h8000_0000; end
                default: begin o = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
            endcase
            issue(o, a, b, nb, nd);
            model(o, a, b);
            n_checks++;
            if (nb != exp_lat(o) || nd != 1) begin
                n_fail++; $display("FAIL mult[%0d] timing: got busy=%0d done=%0d required busy=%0d done=1", i, nb, nd, exp_lat(o));
            end
            n_checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL mult[%0d] op%0d %h*%h: got %h_%h required %h_%h", i, o, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  o;
        logic [31:0] a, b;
        int nb, nd;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       begin o = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; end
                1:       begin o = 3'd3; a = 32'd100; b = 32'd7; end
                2:       begin o = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       begin o = 3'd3; a = 32'd5; b = 32'd0; end
                4:       begin o = 3'd2; a = 32'hFFFF_FFF7; b = 32'd0; end
                5:       begin o = 3'd2; a = 32'd7; b = 32'hFFFF_FFFE; end
                default: begin o = 3'($urandom_range(2, 3)); a = $urandom; b = rand_divisor(); end
            endcase
            issue(o, a, b, nb, nd);
            model(o, a, b);
            n_checks++;
            if (nb != DIV_LAT || nd != 1) begin
                n_fail++; $display("FAIL div[%0d] timing: got busy=%0d done=%0d required busy=%0d done=1", i, nb, nd, DIV_LAT);
            end
            n_checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL div[%0d] op%0d %h/%h: got hi=%h lo=%h required hi=%h lo=%h", i, o, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_move_and_invalid();
        logic [2:0]  o;
        logic [31:0] a;
        int nb, nd;
        for (int i = 0; i < 8; i++) begin
            o = 3'(4 + (i % 4));
            a = $urandom;
            issue(o, a, $urandom, nb, nd);
            model(o, a, 32'd0);
            n_checks++;
            if (nb != 0 || nd != 0 || hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL move[%0d] op%0d: got busy=%0d done=%0d hi=%h lo=%h required 0 0 %h %h", i, o, nb, nd, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_read_stall();
        int ns, bad;
        @(negedge clk);
        op = 3'd3; srca = 32'd1000; srcb = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; read_req = 1'b1;
        #1;
        ns = 0; bad = 0;
        while (busy === 1'b1 && ns < 100) begin
            if (stall !== 1'b1) bad++;
            ns++;
            @(negedge clk);
        end
        model(3'd3, 32'd1000, 32'd9);
        n_checks++;
        if (bad != 0 || ns != DIV_LAT) begin
            n_fail++; $display("FAIL read_stall: got %0d unstalled of %0d busy cycles required 0 of %0d", bad, ns, DIV_LAT);
        end
        n_checks++;
        if (stall !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL read_after: got stall=%b hi=%h lo=%h required 0 %h %h", stall, hi, lo, m_hi, m_lo);
        end
        read_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ns, bad, nd;
        logic [31:0] ma, mb;
        ma = $urandom; mb = $urandom;
        @(negedge clk);
        op = 3'd2; srca = 32'hFFFF_FF00; srcb = 32'd3; start = 1'b1;
        @(negedge clk);
        op = 3'd0; srca = ma; srcb = mb;
        #1;
        ns = 0; bad = 0;
        while (busy === 1'b1 && ns < 100) begin
            if (stall !== 1'b1) bad++;
            ns++;
            @(negedge clk);
        end
        model(3'd2, 32'hFFFF_FF00, 32'd3);
        n_checks++;
        if (bad != 0 || ns != DIV_LAT) begin
            n_fail++; $display("FAIL b2b_stall: got %0d unstalled of %0d busy cycles required 0 of %0d", bad, ns, DIV_LAT);
        end
        n_checks++;
        if (stall !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL b2b_div: got stall=%b hi=%h lo=%h required 0 %h %h", stall, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        ns = 0; nd = 0;
        while (busy === 1'b1 && ns < 100) begin
            ns++;
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        model(3'd0, ma, mb);
        n_checks++;
        if (ns != MULT_LAT || nd != 1 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL b2b_mult: got busy=%0d done=%0d %h_%h required %0d 1 %h_%h", ns, nd, hi, lo, MULT_LAT, m_hi, m_lo);
        end
    endtask

    task automatic test_flush();
        int nb, nd, k;
        issue(3'd4, 32'h1234, 32'd0, nb, nd);
        issue(3'd5, 32'h5678, 32'd0, nb, nd);
        model(3'd4, 32'h1234, 32'd0);
        model(3'd5, 32'h5678, 32'd0);
        n_checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++; $display("FAIL preset: got %h/%h required 00001234/00005678", hi, lo);
        end
        // flush while idle suppresses an MTHI
        @(negedge clk);
        op = 3'd4; srca = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (hi !== m_hi || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got hi=%h busy=%b required %h 0", hi, busy, m_hi);
        end
        // flush at divide cycle 10
        @(negedge clk);
        op = 3'd2; srca = 32'd77; srcb = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int c = 1; c < 10; c++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        if (done === 1'b1) nd++;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || nd != 0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL flush_div: got busy=%b done=%0d hi=%h lo=%h required 0 0 %h %h", busy, nd, hi, lo, m_hi, m_lo);
        end
        // flush on the multiply write cycle
        @(negedge clk);
        op = 3'd1; srca = 32'd6; srcb = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < MULT_LAT + 2) begin
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL flush_mul_done: got done=%b required 1 before flush", done);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL flush_mul_gate: got done=%b required 0", done);
        end
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL flush_mul: got busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int nb, nd;
        @(negedge clk);
        op = 3'd1; srca = 32'd1234; srcb = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy: got busy=%b required 1", busy);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        issue(3'd1, 32'd3, 32'd4, nb, nd);
        n_checks++;
        if (nb != MULT_LAT || hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++; $display("FAIL post_reset_mult: got busy=%0d %h_%h required %0d 0_c", nb, hi, lo, MULT_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move_and_invalid();
        test_read_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller for the MIPS multiply/divide resource and owner of the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, with operands already forwarded.
- Runs multiplies with a fixed multi-cycle latency and divides with an iterative radix-2 divider.
- Tells the hazard unit to stall any HI/LO consumer or new multdiv instruction while an operation is in flight.

Parameters:
- MULT_LAT, 2, cycles the MUL state occupies before HI/LO are written (range 1..8).
- DIV_ITERS, 32, restoring-division iterations (fixed at 32 for 32-bit operands).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  valid multdiv instruction present in execute this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- srca  in  32  rs operand, forwarded.
- srcb  in  32  rt operand, forwarded.
- read_req  in  1  MFHI/MFLO present in execute.
- flush  in  1  exception/pipeline flush; aborts in-flight op.
- stall  out  1  to hazard unit; freezes execute and earlier stages.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on the cycle HI/LO are written by MUL/FIX.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, hi=0, lo=0, counters=0.
  - stall=0, busy=0, done=0.
- States: IDLE, MUL, DIV, FIX.
- stall = busy & (start | read_req). It is combinational. Flush does not force stall.
- Accept rule: an op is accepted only when state=IDLE & start & ~flush. A start held under stall is accepted on the first cycle state returns to IDLE.
- MTHI/MTLO:
  - Accepted in IDLE; hi (resp. lo) <= srca at that edge.
  - State stays IDLE. No done pulse.
- MULT/MULTU:
  - Latch operands and signedness, then go to MUL with cnt=MULT_LAT-1.
  - The 64-bit product (signed or unsigned) is computed from the latched operands.
  - MUL decrements cnt. On the cycle cnt=0, {hi,lo} <= product, done=1, next state IDLE.
  - Total: MULT_LAT cycles busy after the accept edge.
- DIV/DIVU:
  - Latch |srca| and |srcb| (abs only when signed), plus sign bits; go to DIV with cnt=31.
  - Each DIV cycle performs one restoring step (shift remainder:quotient left 1, trial subtract divisor, set quotient bit).
  - After the cnt=0 step, go to FIX.
  - FIX applies signs: quotient is negated iff the dividend and divisor signs differ; remainder takes the dividend's sign. Then lo<=quotient, hi<=remainder, done=1, next IDLE.
  - Total: 33 cycles busy after the accept edge.
- Divide by zero:
  - Full latency still runs.
  - Result is hi=srca (original, unsigned view), lo=32'hFFFFFFFF.
  - The sign fixup is bypassed for both signed and unsigned forms.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The natural magnitude path produces this; no special case is needed.
- Flush:
  - If busy, the operation is aborted: next state IDLE, hi/lo unchanged, no done.
  - If IDLE, start is ignored that cycle, including MTHI/MTLO.
  - Flush in the same cycle as the MUL/FIX write cycle: the write is suppressed.
- read_req in IDLE: no stall. hi/lo outputs reflect all completed writes (registered values).
- op 110/111 with start in IDLE: no action.
- Reset mid-operation: immediately returns to the reset state; partial results are discarded.
- hi/lo change only on completing MUL/FIX, MTHI/MTLO, or reset.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MULT_LAT=2:
  - busy for 2 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse once.
  - MULT with the same operands gives hi=0, lo=1.
- DIV -7 / 2:
  - After 33 busy cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 100/7 gives lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU 5/0 gives hi=5, lo=0xFFFFFFFF after 33 cycles.
- MFHI (read_req) issued one cycle after DIV accept:
  - stall=1 for the remaining busy cycles and drops the cycle after done.
  - A back-to-back MULT issued during DIV is held by stall, then accepted.
- Flush at DIV cycle 10 with hi=0x1234, lo=0x5678 preset via MTHI/MTLO:
  - State returns to IDLE, no done, hi/lo stay 0x1234/0x5678.
  - Assert resetn=0 mid-MUL: outputs go to zero asynchronously.
